// File: rtl/stripe_pkg.sv
// stripe_pkg: shared types and constants for the lane striper and unstriper
package stripe_pkg;
    localparam int DATA_W = 32;
    localparam int LANE0  = 0;
    localparam int LANE1  = 1;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HALF = 1'b1
    } state_t;
endpackage

// File: rtl/byte_stripe.sv
// byte_stripe: pairs consecutive words onto lane_0/lane_1, held two clk_2f cycles each
module byte_stripe #(
    parameter int DATA_W    = stripe_pkg::DATA_W,
    parameter int FLUSH_CYC = 4,
    parameter int CNT_W     = 16
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_0,
    output logic [DATA_W-1:0] lane_0,
    output logic              valid_1,
    output logic [DATA_W-1:0] lane_1,
    output logic [CNT_W-1:0]  pair_cnt
);
    import stripe_pkg::*;
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYC - 1);
    state_t state, state_n;
    logic [DATA_W-1:0] hold_q;
    logic [3:0] idle_cnt;
    logic out_hold;
    logic emit_pair, emit_flush, emit;
    always_ff @(posedge clk_2f) begin
        state <= reset ? ST_IDLE : state_n;
    end
    always_comb begin
        state_n = (state == ST_IDLE) ? (valid_in ? ST_HALF : ST_IDLE) : (emit ? ST_IDLE : ST_HALF);
    end
    // a pairing word arriving on the flush cycle takes priority over the flush
    always_comb begin
        emit_pair  = (state == ST_HALF) && valid_in;
        emit_flush = (state == ST_HALF) && !valid_in && (idle_cnt == FLUSH_LAST);
        emit       = emit_pair || emit_flush;
    end
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            hold_q   <= '0;
            idle_cnt <= '0;
            pair_cnt <= '0;
        end else begin
            if (state == ST_IDLE && valid_in) begin
                hold_q   <= data_in;
                idle_cnt <= '0;
            end else if (state == ST_HALF && !valid_in) begin
                idle_cnt <= idle_cnt + 4'd1;
            end
            if (emit)
                pair_cnt <= pair_cnt + 1'b1;
        end
    end
    // out_hold stretches each emitted pair to a second cycle before clearing
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            valid_0  <= 1'b0;
            valid_1  <= 1'b0;
            lane_0   <= '0;
            lane_1   <= '0;
            out_hold <= 1'b0;
        end else if (emit) begin
            valid_0  <= 1'b1;
            valid_1  <= emit_pair;
            lane_0   <= hold_q;
            lane_1   <= emit_pair ? data_in : '0;
            out_hold <= 1'b1;
        end else if (out_hold) begin
            out_hold <= 1'b0;
        end else begin
            valid_0 <= 1'b0;
            valid_1 <= 1'b0;
            lane_0  <= '0;
            lane_1  <= '0;
        end
    end
endmodule

// File: tb/tb_byte_stripe.sv
// tb_byte_stripe: scoreboard bench; expected lane events queued at drive time, checked as they appear
module tb_byte_stripe;
    localparam int FLUSH = 4;
    localparam int CW = 8;
    typedef struct {
        logic        v0;
        logic [31:0] l0;
        logic        v1;
        logic [31:0] l1;
        logic [CW-1:0] cnt;
    } exp_t;
    logic clk_2f = 1'b0;
    logic reset, valid_in;
    logic [31:0] data_in;
    logic valid_0, valid_1;
    logic [31:0] lane_0, lane_1;
    logic [CW-1:0] pair_cnt;
    exp_t exp_q[$];
    exp_t cur;
    int n_tests = 0;
    int n_fail = 0;
    int mcnt = 0;
    logic pending = 1'b0;
    logic [31:0] prev;
    int idle = 0;
    logic [CW-1:0] ecnt = '0;
    byte_stripe #(.DATA_W(32), .FLUSH_CYC(FLUSH), .CNT_W(CW)) dut (
        .clk_2f(clk_2f), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .valid_0(valid_0), .lane_0(lane_0), .valid_1(valid_1), .lane_1(lane_1),
        .pair_cnt(pair_cnt)
    );
    always #5 clk_2f = ~clk_2f;
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask
    task automatic push(input logic v1, input logic [31:0] l1);
        ecnt = ecnt + 1'b1;
        exp_q.push_back('{1'b1, prev, v1, l1, ecnt});
        pending = 1'b0;
    endtask
    task automatic step(input logic v, input logic [31:0] d);
        valid_in = v;
        data_in = d;
        if (reset) begin
            pending = 1'b0;
            ecnt = '0;
        end else if (v) begin
            if (pending) push(1'b1, d);
            else begin
                pending = 1'b1;
                prev = d;
                idle = 0;
            end
        end else if (pending) begin
            idle++;
            if (idle == FLUSH) push(1'b0, 32'h0);
        end
        @(posedge clk_2f);
        #1;
    endtask
    task automatic idles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0);
    endtask
    // each emitted event must stay two cycles, then either a new event or all-zero lanes
    always @(negedge clk_2f) begin
        if (reset) mcnt = 0;
        if (valid_0 && (mcnt == 0 || mcnt == 2)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_emit", {valid_0, lane_0, valid_1, lane_1}, 66'h0);
                mcnt = 0;
            end else begin
                cur = exp_q.pop_front();
                chk("emit", {valid_0, lane_0, valid_1, lane_1, pair_cnt}, {cur.v0, cur.l0, cur.v1, cur.l1, cur.cnt});
                mcnt = 1;
            end
        end else if (mcnt == 1) begin
            chk("hold", {valid_0, lane_0, valid_1, lane_1, pair_cnt}, {cur.v0, cur.l0, cur.v1, cur.l1, cur.cnt});
            mcnt = 2;
        end else begin
            chk("clear", {valid_0, lane_0, valid_1, lane_1}, 66'h0);
            mcnt = 0;
        end
    end
    initial begin
        reset = 1'b1;
        valid_in = 1'b0;
        data_in = '0;
        step(1'b0, 32'h0);
        step(1'b0, 32'h0);
        chk("reset_cnt", pair_cnt, 0);
        chk("reset_valid", {valid_0, valid_1}, 2'b00);
        reset = 1'b0;
        idles(2);
        step(1'b1, 32'hA1);
        step(1'b1, 32'hB2);
        step(1'b1, 32'hC3);
        step(1'b1, 32'hD4);
        idles(4);
        chk("back2back_cnt", pair_cnt, 2);
        step(1'b1, 32'hDEADBEEF);
        idles(8);
        step(1'b1, 32'h11);
        idles(3);
        step(1'b1, 32'h22);
        idles(4);
        chk("noflush_cnt", pair_cnt, 4);
        step(1'b1, 32'h55);
        reset = 1'b1;
        step(1'b0, 32'h0);
        chk("midreset_cnt", pair_cnt, 0);
        chk("midreset_lanes", {valid_0, lane_0, valid_1, lane_1}, 66'h0);
        reset = 1'b0;
        step(1'b1, 32'h66);
        step(1'b1, 32'h77);
        idles(6);
        reset = 1'b1;
        step(1'b0, 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 257; i++) begin
            if (i % 2 == 1) begin
                step(1'b1, {16'hA000, 16'(i)});
                step(1'b0, 32'h0);
                step(1'b1, {16'hB000, 16'(i)});
                step(1'b0, 32'h0);
            end else begin
                step(1'b1, {16'hC000, 16'(i)});
                step(1'b1, {16'hD000, 16'(i)});
            end
        end
        idles(6);
        chk("wrap_cnt", pair_cnt, 1);
        chk("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
